// File: rtl/sb_issue_ctrl.sv
// In-order scoreboard issue/commit controller: per-entry FREE/ALLOC/ISSUED/DONE
// tracking with circular alloc, issue and commit pointers and out-of-order writeback.
package config_pkg;
  localparam int unsigned NR_SB_ENTRIES = 4;
endpackage

module sb_issue_ctrl #(
  parameter int unsigned NR_ENTRIES  = config_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = 2,
  localparam int unsigned PW = $clog2(NR_ENTRIES),
  localparam int unsigned CW = PW + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                decoded_valid_i,
  output logic                                decoded_ready_o,
  output logic [PW-1:0]                       alloc_ptr_o,
  output logic                                issue_valid_o,
  output logic [PW-1:0]                       issue_ptr_o,
  input  logic                                issue_ack_i,
  input  logic [NR_WB_PORTS-1:0]              wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][PW-1:0]      wb_ptr_i,
  output logic                                commit_valid_o,
  output logic [PW-1:0]                       commit_ptr_o,
  input  logic                                commit_ack_i,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [CW-1:0]                       count_o
);

  typedef enum logic [1:0] {FREE, ALLOC, ISSUED, DONE} entry_state_t;

  entry_state_t            st [NR_ENTRIES];
  logic [PW-1:0]           alloc_ptr;
  logic [PW-1:0]           issue_ptr;
  logic [PW-1:0]           commit_ptr;
  logic [CW-1:0]           count;
  logic [NR_ENTRIES-1:0]   wb_hit;
  logic                    alloc_fire;
  logic                    issue_fire;
  logic                    commit_fire;

  // Occupancy flags come from the registered count only, so a same-cycle
  // commit never opens a slot in a full buffer.
  assign full_o          = (count == CW'(NR_ENTRIES));
  assign empty_o         = (count == '0);
  assign decoded_ready_o = !full_o;
  assign count_o         = count;

  assign alloc_ptr_o    = alloc_ptr;
  assign issue_ptr_o    = issue_ptr;
  assign commit_ptr_o   = commit_ptr;
  assign issue_valid_o  = (st[issue_ptr] == ALLOC);
  assign commit_valid_o = (st[commit_ptr] == DONE);

  assign alloc_fire  = decoded_valid_i && decoded_ready_o;
  assign issue_fire  = issue_valid_o && issue_ack_i;
  assign commit_fire = commit_valid_o && commit_ack_i;

  // A writeback strobe only counts when its target is currently ISSUED.
  always_comb begin
    wb_hit = '0;
    for (int e = 0; e < int'(NR_ENTRIES); e++) begin
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
        if (wb_valid_i[k] && (wb_ptr_i[k] == PW'(e)) && (st[e] == ISSUED)) begin
          wb_hit[e] = 1'b1;
        end
      end
    end
  end

  // Each transition is gated on a distinct current state, so at most one
  // of them can target a given entry in any cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < int'(NR_ENTRIES); e++) st[e] <= FREE;
      alloc_ptr  <= '0;
      issue_ptr  <= '0;
      commit_ptr <= '0;
      count      <= '0;
    end else if (flush_i) begin
      for (int e = 0; e < int'(NR_ENTRIES); e++) st[e] <= FREE;
      alloc_ptr  <= '0;
      issue_ptr  <= '0;
      commit_ptr <= '0;
      count      <= '0;
    end else begin
      for (int e = 0; e < int'(NR_ENTRIES); e++) begin
        if (alloc_fire && (alloc_ptr == PW'(e)))   st[e] <= ALLOC;
        if (issue_fire && (issue_ptr == PW'(e)))   st[e] <= ISSUED;
        if (wb_hit[e])                             st[e] <= DONE;
        if (commit_fire && (commit_ptr == PW'(e))) st[e] <= FREE;
      end
      if (alloc_fire)  alloc_ptr  <= alloc_ptr + PW'(1);
      if (issue_fire)  issue_ptr  <= issue_ptr + PW'(1);
      if (commit_fire) commit_ptr <= commit_ptr + PW'(1);
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/sb_issue_ctrl.md
SB_ISSUE_CTRL -- requirements
Module: sb_issue_ctrl

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default config_pkg::NR_SB_ENTRIES, scoreboard depth; power of two, at least 2.
REQ-002 SHALL have parameter NR_WB_PORTS, default 2, number of functional-unit writeback ports.
REQ-003 SHALL define PW = $clog2(NR_ENTRIES) as the pointer width and CW = PW+1 as the count width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- flush_i  in  1  discard all entries
- decoded_valid_i  in  1  decoded instruction offered
- decoded_ready_o  out  1  slot available
- alloc_ptr_o  out  PW  slot given to the offered instruction
- issue_valid_o  out  1  oldest unissued entry ready to issue
- issue_ptr_o  out  PW  that entry
- issue_ack_i  in  1  FU accepted the issue
- wb_valid_i  in  NR_WB_PORTS  writeback strobes
- wb_ptr_i  in  NR_WB_PORTS x PW  writeback entry ids
- commit_valid_o  out  1  oldest entry done
- commit_ptr_o  out  PW  that entry
- commit_ack_i  in  1  commit stage retired it
- full_o  out  1  count == NR_ENTRIES
- empty_o  out  1  count == 0
- count_o  out  CW  occupied entries

Function
REQ-006 Each entry SHALL hold a registered state in FREE, ALLOC, ISSUED or DONE.
REQ-007 Allocate SHALL occur when decoded_valid_i && decoded_ready_o: the slot at the alloc pointer goes FREE->ALLOC and the alloc pointer increments.
REQ-008 decoded_ready_o SHALL equal !full_o from registered count; a commit in the same cycle SHALL NOT enable allocation into a full buffer.
REQ-009 issue_valid_o SHALL be 1 iff the entry at the issue pointer is ALLOC (registered state; combinational output).
REQ-010 On issue_valid_o && issue_ack_i that entry SHALL go ALLOC->ISSUED and the issue pointer SHALL increment; issue_ack_i SHALL be ignored while issue_valid_o=0.
REQ-011 Alloc to earliest issue_valid_o SHALL take one cycle.
REQ-012 A wb_valid_i[k] strobe SHALL move entry wb_ptr_i[k] ISSUED->DONE; a strobe on a non-ISSUED entry SHALL be ignored (no state change).
REQ-013 Ports SHALL be processed independently, and multiple ports hitting distinct entries in one cycle SHALL all take effect.
REQ-014 commit_valid_o SHALL be 1 iff the entry at the commit pointer is DONE, so commit is in order even when writeback is out of order.
REQ-015 On commit_valid_o && commit_ack_i the entry SHALL go DONE->FREE and the commit pointer SHALL increment.
REQ-016 Writeback to commit_valid_o SHALL take one cycle.
REQ-017 All pointers SHALL wrap NR_ENTRIES-1 -> 0.
REQ-018 count_o SHALL be updated +1 on alloc, -1 on commit, and stay unchanged on both or neither; it SHALL never exceed NR_ENTRIES or underflow.
REQ-019 full_o and empty_o SHALL be decoded from count_o, never from pointer equality.
REQ-020 Alloc, issue, writeback and commit SHALL all be legal in the same cycle on different entries.
REQ-021 flush_i SHALL take priority over every other event in its cycle: next cycle all entries FREE, all pointers 0, count 0; same-cycle alloc, ack and wb SHALL be discarded.

Reset
REQ-022 While rst_i=1 (asynchronously), all entries SHALL be FREE, all pointers 0 and count_o 0.
REQ-023 Output values in reset SHALL be: decoded_ready_o=1, issue_valid_o=0, commit_valid_o=0, full_o=0, empty_o=1, alloc/issue/commit_ptr_o=0.
REQ-024 Reset asserted mid-operation SHALL abandon all entries identically to flush.

Verification (NR_ENTRIES=4, NR_WB_PORTS=2)
REQ-025 Assert rst_i mid-cycle with 3 entries live -> outputs immediately reach REQ-023 values without waiting for a clock edge.
REQ-026 Hold decoded_valid_i=1 for 5 cycles with no issue -> alloc_ptr_o 0,1,2,3; count_o=4, full_o=1, decoded_ready_o=0 in cycle 5; 5th not allocated.
REQ-027 Run a single instruction, ack issue on first issue_valid_o, wb port0 ptr0 next cycle -> commit_valid_o=1, commit_ptr_o=0 the cycle after wb; ack -> empty_o=1.
REQ-028 Issue entries 0 and 1, wb ptr1 via port1 first, ptr0 two cycles later -> commit_valid_o=0 until the cycle after ptr0 wb; commits retire 0 then 1.
REQ-029 Stream 6 instructions through alloc/issue/wb/commit -> pointers wrap 3->0, count_o never exceeds 4, commits in allocation order.
REQ-030 Three entries (ALLOC, ISSUED, DONE), assert flush_i with simultaneous wb on the ISSUED entry and commit_ack_i -> next cycle count_o=0, empty_o=1, all pointers 0, no commit_valid_o.
